// File: rtl/decodificador_multiplexado_pkg.sv
// Shared constants for the multiplexed 7-segment decoder:
// segment codes, blank code and segment bit positions.
package decodificador_pkg;

  // Bit positions inside the segment bus {dp,g,f,e,d,c,b,a}
  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  localparam logic [6:0] SEG_APAGADO = 7'h00;

  // Active-high g..a codes for hex digits 0..F
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/decodificador_multiplexado_if.sv
// Datapath-to-display bundle: load handshake in, digit enables and
// segment bus out. master = value producer, slave = decoder.
interface decodificador_multiplexado_if #(
  parameter int unsigned DIGITOS = 4
);
  logic [4*DIGITOS-1:0] Entrada;
  logic [DIGITOS-1:0]   puntos;
  logic                 cargar;
  logic                 ocupado;
  logic [DIGITOS-1:0]   Habilita;
  logic [7:0]           Salida;

  modport master (
    output Entrada, puntos, cargar,
    input  ocupado, Habilita, Salida
  );

  modport slave (
    input  Entrada, puntos, cargar,
    output ocupado, Habilita, Salida
  );
endinterface

// File: rtl/decodificador_multiplexado_hex_a_7seg.sv
// Combinational hex nibble to 7-segment (g..a) code.
module hex_a_7seg
  import decodificador_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segmentos
);

  // Table lookup of the segment pattern
  always_comb begin
    segmentos = SEG_HEX[nibble];
  end

endmodule

// File: rtl/decodificador_multiplexado.sv
// Multiplexed DIGITOS-digit hex display driver with refresh prescaler,
// digit scan and frame-aligned load handshake.
// Optional macro BLANCO_CEROS_EN: blank leading zero digits (digit 0 never).
module decodificador_multiplexado
  import decodificador_pkg::*;
#(
  parameter int unsigned DIGITOS  = 4,
  parameter int unsigned PRESCALA = 50000
) (
  input logic clk,
  input logic rst,
  decodificador_multiplexado_if.slave bus
);

  localparam int unsigned ANCHO_CONT = $clog2(PRESCALA);
  localparam int unsigned ANCHO_IND  = $clog2(DIGITOS);
  localparam logic [ANCHO_CONT-1:0] ULTIMA_CUENTA = ANCHO_CONT'(PRESCALA - 1);
  localparam logic [ANCHO_IND-1:0]  ULTIMO_DIGITO = ANCHO_IND'(DIGITOS - 1);

  logic [ANCHO_CONT-1:0] contador, contador_sig;
  logic [ANCHO_IND-1:0]  indice, indice_sig;
  logic [4*DIGITOS-1:0]  sombra, sombra_sig, mostrado, mostrado_sig;
  logic [DIGITOS-1:0]    sombra_dp, sombra_dp_sig, mostrado_dp, mostrado_dp_sig;
  logic                  pendiente, pendiente_sig;
  logic                  tick, fin_trama;
  logic [3:0]            nibble_sel;
  logic [6:0]            seg_hex, seg_final;
  logic                  dp_sel;

  hex_a_7seg u_hex (
    .nibble    (nibble_sel),
    .segmentos (seg_hex)
  );

  // Prescaler, scan pointer and shadow/displayed next-state logic
  always_comb begin
    tick            = (contador == ULTIMA_CUENTA);
    fin_trama       = tick && (indice == ULTIMO_DIGITO);
    contador_sig    = tick ? '0 : contador + ANCHO_CONT'(1);
    indice_sig      = indice;
    sombra_sig      = sombra;
    sombra_dp_sig   = sombra_dp;
    mostrado_sig    = mostrado;
    mostrado_dp_sig = mostrado_dp;
    pendiente_sig   = pendiente;
    if (tick) begin
      indice_sig = fin_trama ? '0 : indice + ANCHO_IND'(1);
    end
    if (bus.cargar) begin
      sombra_sig    = bus.Entrada;
      sombra_dp_sig = bus.puntos;
    end
    // A load landing on the frame boundary goes straight to the display,
    // so it is newer than anything waiting in the shadow.
    if (fin_trama) begin
      pendiente_sig = 1'b0;
      if (bus.cargar) begin
        mostrado_sig    = bus.Entrada;
        mostrado_dp_sig = bus.puntos;
      end else if (pendiente) begin
        mostrado_sig    = sombra;
        mostrado_dp_sig = sombra_dp;
      end
    end else if (bus.cargar) begin
      pendiente_sig = 1'b1;
    end
  end

  // Segment pattern of the digit that becomes active on the next edge
  always_comb begin
    nibble_sel = mostrado_sig[{indice_sig, 2'b00} +: 4];
    dp_sel     = mostrado_dp_sig[indice_sig];
`ifdef BLANCO_CEROS_EN
    begin
      logic [DIGITOS-1:0] apagar;
      logic               cero_arriba;
      apagar      = '0;
      cero_arriba = 1'b1;
      for (int unsigned k = DIGITOS; k > 0; k--) begin
        cero_arriba = cero_arriba && (mostrado_sig[4*(k-1) +: 4] == 4'h0);
        apagar[k-1] = cero_arriba;
      end
      apagar[0] = 1'b0;
      seg_final = apagar[indice_sig] ? SEG_APAGADO : seg_hex;
    end
`else
    seg_final = seg_hex;
`endif
  end

  // State and registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      contador     <= '0;
      indice       <= '0;
      sombra       <= '0;
      sombra_dp    <= '0;
      mostrado     <= '0;
      mostrado_dp  <= '0;
      pendiente    <= 1'b0;
      bus.ocupado  <= 1'b0;
      bus.Habilita <= DIGITOS'(1);
      bus.Salida   <= {1'b0, SEG_HEX[0]};
    end else begin
      contador     <= contador_sig;
      indice       <= indice_sig;
      sombra       <= sombra_sig;
      sombra_dp    <= sombra_dp_sig;
      mostrado     <= mostrado_sig;
      mostrado_dp  <= mostrado_dp_sig;
      pendiente    <= pendiente_sig;
      bus.ocupado  <= pendiente_sig;
      bus.Habilita <= DIGITOS'(1) << indice_sig;
      bus.Salida   <= {dp_sel, seg_final};
    end
  end

endmodule

// File: doc/decodificador_multiplexado.md
Name: decodificador_multiplexado

Overview:
- Parametrised successor of the single-digit hex/7-segment decoder.
- Drives DIGITOS multiplexed 7-segment digits from one shared segment bus, with a built-in refresh prescaler, digit scan counter and a load handshake.
- A new value is applied only at frame boundaries, so a display never shows a half-old, half-new value.
- Sits between the datapath (value producer) and the board's display pins.

Parameters:
- DIGITOS, 4, number of digits scanned; legal range 2..8.
- PRESCALA, 50000, clock cycles per digit slot; legal range ≥2.
- ANCHO_CONT, $clog2(PRESCALA), prescaler counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- Entrada  in  4*DIGITOS  hex nibbles; nibble k = digit k; digit 0 = least significant.
- puntos  in  DIGITOS  decimal-point request per digit, latched with Entrada.
- cargar  in  1  one-cycle load strobe for Entrada/puntos.
- ocupado  out  1  high while a loaded value awaits frame-boundary commit.
- Habilita  out  DIGITOS  one-hot, active-high digit enable.
- Salida  out  8  segments {dp,g,f,e,d,c,b,a}, active-high.

Behaviour:
- Clocking and reset: one clock (clk); rst synchronous, active-high, sampled on the rising edge of clk.
- Registers: contador (ANCHO_CONT bits), indice (digit pointer), sombra/sombra_dp (shadow), mostrado/mostrado_dp (displayed), pendiente.
- Reset values: contador=0, indice=0, sombra=0, mostrado=0, all dp=0, pendiente=0, ocupado=0, Habilita=1 (digit 0), Salida=8'h3F (hex "0").
- tick: asserted the cycle contador==PRESCALA-1. On tick, contador→0; otherwise contador+1.
- Scan on tick:
  - indice→indice+1, wrapping DIGITOS-1→0.
  - fin_trama = tick && indice==DIGITOS-1.
- Outputs are registered and change on the same edge as indice. Each is derived from the next indice and next mostrado:
  - Habilita = 1<<indice.
  - Salida[6:0] = hex code of mostrado nibble[indice].
  - Salida[7] = mostrado_dp[indice].
- Hex codes (g..a): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Load handshake:
  - cargar=1 copies Entrada/puntos into sombra and sets pendiente.
  - On fin_trama with pendiente=1: mostrado←sombra, pendiente←0.
  - The first digit of the new frame (digit 0) shows the new value.
  - ocupado = pendiente (registered).
- Boundary cases:
  - cargar while pendiente=1: sombra overwritten, last write wins, pendiente stays 1.
  - cargar in the same cycle as fin_trama: Entrada/puntos bypass straight into mostrado; pendiente←0; sombra also updated.
  - cargar while pendiente=0 and not at frame end: normal shadow load.
  - Wrap: indice never exceeds DIGITOS-1.
  - rst mid-frame or with a pending load: the pending value is discarded and all registers return to reset values on that edge.
- Latency:
  - Load to visible on digit 0: ≤ DIGITOS*PRESCALA cycles.
  - Digit slot period: exactly PRESCALA cycles.
  - Full frame: DIGITOS*PRESCALA cycles.

Optional Feature:
- Macro: BLANCO_CEROS_EN.
- Defined (leading-zero blanking): Salida[6:0]=0 for any digit k>0 whose nibble and all higher nibbles of mostrado are 0. Digit 0 is never blanked. dp is unaffected.
- Undefined: every digit always shows its hex code; no blanking logic is synthesised.

Decomposition:
- Package decodificador_pkg:
  - localparams for the 16 segment codes (array SEG_HEX);
  - SEG_APAGADO=7'h00;
  - segment bit index constants.
- Sub-module hex_a_7seg: combinational nibble → 7-bit code. Instantiated once, on the selected nibble.

Test Plan (DIGITOS=4, PRESCALA=4; all entries are stimulus → required response):
1. Reset: rst=1 for 2 cycles → Habilita=4'b0001, Salida=8'h3F, ocupado=0. Release → Habilita walks 0001→0010→0100→1000→0001, each held exactly 4 cycles.
2. Load 16'h8B37 with puntos=0 mid-frame:
   - ocupado=1 until fin_trama;
   - next frame: digit0 Salida=07, d1=4F, d2=7C, d3=7F;
   - ocupado=0.
3. Two cargar in one frame (16'h1111, then 16'h2222) → only 2222 displayed (all digits Salida=5B); no frame ever shows 1111.
4. cargar with 16'h00F0 exactly on the fin_trama cycle → committed immediately; next frame digit1 = 71, others 3F; ocupado never rises.
5. puntos=4'b0100 with 16'h0003, BLANCO_CEROS_EN defined:
   - d0=4F, d1=00, d2=80 (dp only), d3=00.
   - With the macro undefined: d1=3F, d2=BF, d3=3F.
6. rst asserted while pendiente=1 → next edge: ocupado=0, Habilita=0001, Salida=3F. The pending value never appears.
